fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the RISC-V core.
- Drives the program counter register's `pc_write`/`next_pc` inputs.
- Runs a request/ready handshake with instruction memory.
- Holds the fetched word for decode.
- Arbitrates next-PC sources: trap > redirect > sequential.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.
- `TRAP_VECTOR`, 32'h0000_0100, target on trap or misaligned redirect.

- `clk`  in  1  system clock.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `pc`  in  32  current value of the program counter register.
- `pc_write`  out  1  PC load enable; the PC register captures `next_pc` on the next rising edge.
- `next_pc`  out  32  value to load into the PC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ready`  in  1  memory response valid; data is on `imem_rdata`.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_valid`  out  1  `instr`/`instr_pc` valid for decode.
- `instr`  out  32  held instruction.
- `instr_pc`  out  32  address of `instr`.
- `decode_ready`  in  1  decode accepts `instr` this cycle.
- `stall`  in  1  hazard stall; blocks sequential advance only.
- `redirect_valid`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_target`  in  32  branch/jump target.
- `trap`  in  1  exception/interrupt request; one-cycle pulse.
- `misalign_fault`  out  1  registered one-cycle pulse when a redirect target has `[1:0]` != 0.
- `perf_fetches`  out  32  count of completed fetches (see Configuration).
- `perf_stall_cycles`  out  32  cycles in ISSUE with `instr_valid` high and not advancing (see Configuration).

## Operation
- States: BOOT, FETCH, DRAIN, ISSUE.
- `pc_write` and `next_pc` are combinational from state and inputs. All other outputs are registered.
- While `pc_write` = 0, `next_pc` = `pc`.

BOOT (reset state):
- `pc_write`=1, `next_pc`=RESET_VECTOR.
- Next state: FETCH.

FETCH:
- `imem_req`=1.
- On `imem_ready`: capture `imem_rdata` → `instr` and `pc` → `instr_pc`, set `instr_valid`; next state ISSUE.

ISSUE:
- Advance when `decode_ready` && !`stall`: `pc_write`=1, `next_pc`=`pc`+4 (mod 2^32, wraps at 32'hFFFF_FFFC→0), clear `instr_valid`, next state FETCH.
- Otherwise hold all outputs.

Redirect and trap, in FETCH or ISSUE:
- Trap wins over redirect, and both win over sequential advance.
- Trap: `pc_write`=1, `next_pc`=TRAP_VECTOR.
- Redirect:
  - `pc_write`=1, `next_pc`=`redirect_target`.
  - If `redirect_target[1:0]` != 0, behave as a trap (`next_pc`=TRAP_VECTOR) and pulse `misalign_fault` the next cycle.
- `instr_valid` clears the next cycle.
- Next state:
  - From ISSUE: FETCH.
  - From FETCH with `imem_ready`=1 the same cycle: FETCH; the returned word is discarded.
  - From FETCH with `imem_ready`=0: DRAIN.

DRAIN:
- `imem_req`=0; wait for `imem_ready` and discard the data; next state FETCH.
- A trap or redirect in DRAIN reloads the PC (same priority rules); the state stays DRAIN.

Other rules:
- BOOT ignores `trap` and `redirect_valid`.
- `stall` has no effect on trap or redirect.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign_fault`=0, perf counters 0.
  - `pc_write`=1 and `next_pc`=RESET_VECTOR (BOOT decode).
- First `imem_req` is asserted in the cycle after the first clock edge with `reset_n` high.
- `imem_ready` in cycle N → `instr_valid` high in cycle N+1.
- Minimum loop, with zero-wait memory and decode always ready: 3 cycles per instruction (FETCH, ISSUE, FETCH...).
- Redirect in cycle N → `imem_addr`=target in cycle N+1 (when not draining).
- Reset asserted mid-fetch: state returns to BOOT immediately. The outstanding memory response is not tracked; memory is reset on the same `reset_n`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetches` increments on every accepted `imem_ready` in FETCH.
  - `perf_stall_cycles` increments on every ISSUE cycle with `instr_valid`=1 and no advance, redirect or trap.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- `FETCH_PERF_EN` undefined: both ports are tied to 32'h0 and no counter flops are synthesized.

## Test plan
- Reset release, zero-wait memory, decode always ready: `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` pulses every 3 cycles with matching `instr_pc`.
- `stall`=1 for 4 cycles in ISSUE with `instr`=0x00500093: `instr`/`instr_pc` held, `pc_write`=0; PC advances to +4 one cycle after the stall drops. With `FETCH_PERF_EN`, `perf_stall_cycles`=4.
- `redirect_valid` with target 0x40 in FETCH while `imem_ready`=0 (memory responds 2 cycles later): DRAIN, data discarded; next `imem_addr`=0x40 and `instr_pc`=0x40.
- `trap` and `redirect_valid` (target 0x80) in the same ISSUE cycle: `next_pc`=0x100.
- `redirect_target`=0x42: `next_pc`=0x100, `misalign_fault` pulses for one cycle.
- PC at 0xFFFF_FFFC advances: `next_pc`=0x0. Also `reset_n` pulse mid-DRAIN: outputs return to reset values and fetching restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch controller for the RISC-V core. It drives the PC
//   register load port, runs a request/ready handshake with instruction
//   memory, holds the fetched word for decode and arbitrates the next-PC
//   source (trap > redirect > sequential).
//
//   Optional feature macro: FETCH_PERF_EN (enables the two performance
//   counters; without it both counter ports read 32'h0 and no counter flops
//   exist).
//
// Ports
//   clk               system clock
//   reset_n           asynchronous active-low reset
//   pc                current PC register value
//   pc_write/next_pc  PC load enable / load value (combinational)
//   imem_req          fetch request (registered)
//   imem_addr         fetch address, always equal to pc
//   imem_ready        memory response valid, word on imem_rdata
//   imem_rdata        fetched instruction word
//   instr_valid       instr/instr_pc valid for decode
//   instr, instr_pc   held instruction and its address
//   decode_ready      decode accepts instr this cycle
//   stall             hazard stall, blocks sequential advance only
//   redirect_valid    taken branch/jump pulse
//   redirect_target   branch/jump target
//   trap              exception/interrupt pulse
//   misalign_fault    one-cycle pulse after a misaligned redirect
//   perf_fetches      completed fetch count
//   perf_stall_cycles ISSUE cycles held without advancing
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  output logic        misalign_fault,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stall_cycles
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, ISSUE} state_t;

  state_t state, state_nxt;
  logic   flow_change;
  logic   misalign_hit;
  logic   advance;
  logic   fetch_done;

  assign imem_addr = pc;

  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b0;
    next_pc      = pc;
    flow_change  = 1'b0;
    misalign_hit = 1'b0;

    // BOOT ignores control-flow changes entirely.
    if (state != BOOT) begin
      flow_change  = trap | redirect_valid;
      // A misaligned redirect only faults when it is the winning source.
      misalign_hit = !trap && redirect_valid && (redirect_target[1:0] != 2'b00);
    end

    advance    = (state == ISSUE) && decode_ready && !stall && !flow_change;
    fetch_done = (state == FETCH) && imem_ready && !flow_change;

    if (state == BOOT) begin
      pc_write = 1'b1;
      next_pc  = RESET_VECTOR;
    end else if (trap || misalign_hit) begin
      pc_write = 1'b1;
      next_pc  = TRAP_VECTOR;
    end else if (redirect_valid) begin
      pc_write = 1'b1;
      next_pc  = redirect_target;
    end else if (advance) begin
      pc_write = 1'b1;
      next_pc  = pc + 32'd4;
    end

    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        // A redirect with no response yet leaves one in flight: drain it.
        if (flow_change)     state_nxt = imem_ready ? FETCH : DRAIN;
        else if (imem_ready) state_nxt = ISSUE;
      end
      ISSUE: if (flow_change || advance) state_nxt = FETCH;
      // The outstanding response is discarded; a redirect here only reloads the PC.
      DRAIN: if (imem_ready) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= BOOT;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= 32'h0;
      instr_pc       <= 32'h0;
      misalign_fault <= 1'b0;
    end else begin
      state          <= state_nxt;
      imem_req       <= (state_nxt == FETCH);
      misalign_fault <= misalign_hit;
      if (fetch_done) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= pc;
      end else if (advance || flow_change) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic        stall_cycle;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  assign stall_cycle = (state == ISSUE) && instr_valid && !advance && !flow_change;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (fetch_done)  fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_cycle) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetches      = fetch_cnt;
  assign perf_stall_cycles = stall_cnt;
`else
  assign perf_fetches      = 32'h0;
  assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. A PC register and an instruction
//   memory with programmable wait states surround the DUT. Expected
//   decode-side words are queued by the stimulus; a monitor pops one per
//   rising instr_valid and compares address and word.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        misalign_fault;
  logic [31:0] perf_fetches;
  logic [31:0] perf_stall_cycles;

  int          mem_wait;
  int          mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc               (pc),
    .pc_write         (pc_write),
    .next_pc          (next_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .decode_ready     (decode_ready),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .trap             (trap),
    .misalign_fault   (misalign_fault),
    .perf_fetches     (perf_fetches),
    .perf_stall_cycles(perf_stall_cycles)
  );

  // PC register loaded by the DUT.
  always_ff @(posedge clk) begin
    if (pc_write) pc <= next_pc;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0008) ? 32'h0050_0093 : ~a;
  endfunction

  // Memory: accepts a request on the first edge it sees imem_req, answers
  // mem_wait cycles later with a one-cycle imem_ready pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_ready <= 1'b0;
      imem_rdata <= 32'h0;
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      mem_addr   <= 32'h0;
    end else begin
      imem_ready <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_ready <= 1'b1;
          imem_rdata <= mem_word(mem_addr);
          mem_busy   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_req && !imem_ready) begin
        if (mem_wait == 0) begin
          imem_ready <= 1'b1;
          imem_rdata <= mem_word(imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_wait - 1;
          mem_addr <= imem_addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    e.pc   = a;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input logic [31:0] addr);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == addr) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: no instr_valid at %h within 60 cycles", addr);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign", {31'h0, misalign_fault}, 32'h0);
    chk("rst_pc_write", {31'h0, pc_write}, 32'h1);
    chk("rst_next_pc", next_pc, 32'h0);
    chk("rst_perf_fetches", perf_fetches, 32'h0);
    chk("rst_perf_stalls", perf_stall_cycles, 32'h0);
  endtask

  // Scoreboard monitor.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: got pc %h word %h, required none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr_pc", instr_pc, e.pc);
          chk("sb_instr", instr, e.word);
        end
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[3];
    int          vcyc[3];
    int          n_addr;
    int          n_v;
    int          cyc;
    bit          prev_req;
    bit          prev_v;
    bit          hit;

    reset_n         = 1'b0;
    decode_ready    = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap            = 1'b0;
    mem_wait        = 0;
    for (int i = 0; i < 3; i++) begin
      addrs[i] = 32'hDEAD_BEEF;
      vcyc[i]  = -100;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    #1 chk_reset_values();
    reset_n = 1'b1;

    // Straight-line fetch: 0x0, 0x4, 0x8 with zero-wait memory.
    push_exp(32'h0000_0000, 32'hFFFF_FFFF);
    push_exp(32'h0000_0004, 32'hFFFF_FFFB);
    push_exp(32'h0000_0008, 32'h0050_0093);
    @(negedge clk);
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    addrs[0] = imem_addr;
    n_addr   = 1;
    n_v      = 0;
    cyc      = 0;
    prev_req = 1'b1;
    prev_v   = 1'b0;
    hit      = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      cyc++;
      if (imem_req && !prev_req && n_addr < 3) begin
        addrs[n_addr] = imem_addr;
        n_addr++;
      end
      if (instr_valid && !prev_v && n_v < 3) begin
        vcyc[n_v] = cyc;
        n_v++;
      end
      prev_req = imem_req;
      prev_v   = instr_valid;
      if (instr_valid && instr_pc == 32'h8) hit = 1'b1;
    end
    chk("seq_addr_1", addrs[1], 32'h4);
    chk("seq_addr_2", addrs[2], 32'h8);
    chk("valid_period_a", vcyc[1] - vcyc[0], 32'd3);
    chk("valid_period_b", vcyc[2] - vcyc[1], 32'd3);

    // Four stall cycles while holding 0x00500093 at 0x8.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_pc_write", {31'h0, pc_write}, 32'h0);
      chk("stall_next_pc", next_pc, 32'h8);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_instr_pc", instr_pc, 32'h8);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("unstall_pc_write", {31'h0, pc_write}, 32'h1);
    chk("unstall_next_pc", next_pc, 32'hC);
`ifdef FETCH_PERF_EN
    chk("perf_stall_cycles", perf_stall_cycles, 32'd4);
    chk("perf_fetches", perf_fetches, 32'd3);
`else
    chk("perf_stall_cycles_off", perf_stall_cycles, 32'h0);
    chk("perf_fetches_off", perf_fetches, 32'h0);
`endif

    // Redirect to 0x40 in FETCH with the response still pending.
    @(negedge clk);
    chk("fetch_c_addr", imem_addr, 32'hC);
    chk("fetch_c_req", {31'h0, imem_req}, 32'h1);
    chk("fetch_c_valid", {31'h0, instr_valid}, 32'h0);
    mem_wait        = 1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    push_exp(32'h0000_0040, 32'hFFFF_FFBF);
    #1;
    chk("redir_pc_write", {31'h0, pc_write}, 32'h1);
    chk("redir_next_pc", next_pc, 32'h40);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drain_req", {31'h0, imem_req}, 32'h0);
    chk("drain_valid", {31'h0, instr_valid}, 32'h0);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (imem_req) hit = 1'b1;
    end
    chk("after_drain_addr", imem_addr, 32'h40);
    chk("after_drain_req", {31'h0, imem_req}, 32'h1);

    // Trap and redirect together in ISSUE: trap wins.
    wait_valid(32'h40);
    mem_wait        = 0;
    trap            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0080;
    push_exp(32'h0000_0100, 32'hFFFF_FEFF);
    #1;
    chk("trap_pc_write", {31'h0, pc_write}, 32'h1);
    chk("trap_next_pc", next_pc, 32'h100);
    @(negedge clk);
    trap           = 1'b0;
    redirect_valid = 1'b0;
    chk("trap_valid_clr", {31'h0, instr_valid}, 32'h0);
    chk("trap_addr", imem_addr, 32'h100);

    // Misaligned redirect to 0x42.
    wait_valid(32'h100);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0042;
    push_exp(32'h0000_0100, 32'hFFFF_FEFF);
    #1;
    chk("misal_next_pc", next_pc, 32'h100);
    chk("misal_pc_write", {31'h0, pc_write}, 32'h1);
    chk("misal_before", {31'h0, misalign_fault}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("misal_pulse", {31'h0, misalign_fault}, 32'h1);
    @(negedge clk);
    chk("misal_after", {31'h0, misalign_fault}, 32'h0);

    // Sequential wrap from 0xFFFF_FFFC.
    wait_valid(32'h100);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC, 32'h0000_0003);
    #1 chk("to_top_next_pc", next_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(32'hFFFF_FFFC);
    push_exp(32'h0000_0000, 32'hFFFF_FFFF);
    #1;
    chk("wrap_pc_write", {31'h0, pc_write}, 32'h1);
    chk("wrap_next_pc", next_pc, 32'h0);

    // Reset pulse while draining.
    wait_valid(32'h0);
    @(negedge clk);
    chk("pre_drain_addr", imem_addr, 32'h4);
    mem_wait        = 3;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mid_drain_req", {31'h0, imem_req}, 32'h0);
    reset_n  = 1'b0;
    mem_wait = 0;
    #1 chk_reset_values();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_exp(32'h0000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    wait_valid(32'h0);
    decode_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
